// File: rtl/reafference_error_integrator_pkg.sv
// Shared types and helpers for the reafference error integrator:
// FSM state encoding, a generic signed clamp and a log2 width helper.
package reafference_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    // Counter width for a power-of-two modulus; never narrower than 1 bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Clamp a signed value (up to 64 bits) into the signed range of w bits.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                               input int                 w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/reafference_error_integrator_saturator.sv
// reafference_saturator: signed IN_W -> OUT_W clamp with a flag that is set
// whenever the input did not fit and had to be clamped.
module reafference_saturator
    import reafference_pkg::*;
#(
    parameter int IN_W  = 26,
    parameter int OUT_W = 24
)(
    input  logic signed [IN_W-1:0]  i_val,
    output logic signed [OUT_W-1:0] o_val,
    output logic                    o_clamped
);

    if (IN_W > 64 || OUT_W > 64 || IN_W < 1 || OUT_W < 2) begin : g_bad_width
        $error("reafference_saturator: widths must lie in 1..64 (OUT_W >= 2)");
    end

    logic signed [63:0] w_wide;
    logic signed [63:0] w_sat;

    // Widen, clamp to the output range and flag any change
    always_comb begin
        w_wide    = 64'(i_val);
        w_sat     = sat(w_wide, OUT_W);
        o_val     = w_sat[OUT_W-1:0];
        o_clamped = (w_sat != w_wide);
    end

endmodule

// File: rtl/reafference_error_integrator.sv
// reafference_error_integrator: leaky, saturating integral of the comparator
// error stream, emitting one correction word per WINDOW accepted samples over a
// valid/ready handshake. The input is never stalled; a window result that meets
// a stalled output is dropped and recorded in the sticky overrun flag.
// Optional feature: define REAFF_INTEG_DEADBAND_EN to zero samples whose
// magnitude is within DEADBAND before they enter the integrator.
module reafference_error_integrator
    import reafference_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int ACC_WIDTH  = 24,
    parameter  int OUT_WIDTH  = 16,
    parameter  int WINDOW     = 8,
    parameter  int LEAK_SHIFT = 4,
    parameter  int OUT_SHIFT  = 4,
    parameter  int DEADBAND   = 2,
    localparam int CNT_W      = clog2_min1(WINDOW)
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [WIDTH-1:0]     error_raw,
    input  logic                        error_valid,
    input  logic                        clear,
    output logic signed [OUT_WIDTH-1:0] corr_data,
    output logic                        corr_valid,
    input  logic                        corr_ready,
    output logic                        sat_flag,
    output logic                        overrun,
    output logic [CNT_W-1:0]            win_cnt
);

    localparam int SUM_W = ACC_WIDTH + 2;

    if (ACC_WIDTH <= WIDTH) begin : g_bad_acc
        $error("reafference_error_integrator: ACC_WIDTH must exceed WIDTH");
    end
    if (WINDOW < 2 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
        $error("reafference_error_integrator: WINDOW must be a power of 2, >= 2");
    end
    if (LEAK_SHIFT < 1 || LEAK_SHIFT > ACC_WIDTH - 1) begin : g_bad_leak
        $error("reafference_error_integrator: LEAK_SHIFT out of range");
    end
    if (OUT_SHIFT < 0 || DEADBAND < 0) begin : g_bad_misc
        $error("reafference_error_integrator: OUT_SHIFT and DEADBAND must be >= 0");
    end

    state_t                      r_state;
    state_t                      w_state_next;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]            r_win_cnt;
    logic signed [OUT_WIDTH-1:0] r_corr_data;
    logic                        r_sat_flag;
    logic                        r_overrun;

    logic signed [WIDTH-1:0]     w_err;
    logic signed [ACC_WIDTH-1:0] w_leak;
    logic signed [SUM_W-1:0]     w_sum;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic                        w_acc_clamped;
    logic signed [ACC_WIDTH-1:0] w_acc_shift;
    logic signed [OUT_WIDTH-1:0] w_corr_next;
    logic                        w_unused_out_clamped;
    logic                        w_sample;
    logic                        w_boundary;
    logic                        w_emit;
    logic                        w_load;
    logic                        w_drop;

    // Sample conditioning: optional deadband replaces small errors with zero
    always_comb begin
        w_err = error_raw;
`ifdef REAFF_INTEG_DEADBAND_EN
        if ((int'(error_raw) >= -DEADBAND) && (int'(error_raw) <= DEADBAND)) begin
            w_err = '0;
        end
`endif
    end

    // Leaky integration in two guard bits above the accumulator width
    always_comb begin
        w_leak      = r_acc >>> LEAK_SHIFT;
        w_sum       = SUM_W'(r_acc) - SUM_W'(w_leak) + SUM_W'(w_err);
        w_acc_shift = w_acc_next >>> OUT_SHIFT;
    end

    reafference_saturator #(
        .IN_W  (SUM_W),
        .OUT_W (ACC_WIDTH)
    ) u_sat_acc (
        .i_val     (w_sum),
        .o_val     (w_acc_next),
        .o_clamped (w_acc_clamped)
    );

    reafference_saturator #(
        .IN_W  (ACC_WIDTH),
        .OUT_W (OUT_WIDTH)
    ) u_sat_out (
        .i_val     (w_acc_shift),
        .o_val     (w_corr_next),
        .o_clamped (w_unused_out_clamped)
    );

    // Window boundary and output-slot decisions for this cycle
    always_comb begin
        w_sample   = error_valid && !clear;
        w_boundary = w_sample && (r_win_cnt == CNT_W'(WINDOW - 1));
        w_emit     = (r_state == EMIT);
        w_load     = w_boundary && (!w_emit || corr_ready);
        w_drop     = w_boundary && w_emit && !corr_ready;
    end

    // FSM state register; EMIT is exactly the "output word pending" condition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: a transfer coinciding with a boundary keeps EMIT (refill)
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (error_valid) w_state_next = ACCUM;
                ACCUM:   if (w_boundary)  w_state_next = EMIT;
                EMIT:    if (corr_ready && !w_boundary) w_state_next = ACCUM;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Integrator, window counter, output word and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_win_cnt   <= '0;
            r_corr_data <= '0;
            r_sat_flag  <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (clear) begin
            r_acc       <= '0;
            r_win_cnt   <= '0;
            r_corr_data <= '0;
            r_sat_flag  <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_sample) begin
            r_acc      <= w_acc_next;
            r_sat_flag <= w_acc_clamped;
            r_win_cnt  <= r_win_cnt + CNT_W'(1);
            if (w_load) begin
                r_corr_data <= w_corr_next;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign corr_valid = (r_state == EMIT);
    assign corr_data  = r_corr_data;
    assign sat_flag   = r_sat_flag;
    assign overrun    = r_overrun;
    assign win_cnt    = r_win_cnt;

endmodule
